// File: rtl/vga_pkg.sv
// Shared VGA timing defaults, derived totals and the per-axis phase type.
// Latency: n/a (declarations only). Backpressure: n/a.
// Phase encoding is Gray-ordered so each ACTIVE->FRONT->SYNC->BACK step flips one bit.
package vga_pkg;

    localparam int CNT_W = 11;

    localparam int DEF_H_DISPLAY = 640;
    localparam int DEF_H_FRONT   = 16;
    localparam int DEF_H_SYNC    = 96;
    localparam int DEF_H_BACK    = 48;
    localparam int DEF_V_DISPLAY = 480;
    localparam int DEF_V_FRONT   = 10;
    localparam int DEF_V_SYNC    = 2;
    localparam int DEF_V_BACK    = 33;

    localparam int DEF_H_TOTAL = DEF_H_DISPLAY + DEF_H_FRONT + DEF_H_SYNC + DEF_H_BACK;
    localparam int DEF_V_TOTAL = DEF_V_DISPLAY + DEF_V_FRONT + DEF_V_SYNC + DEF_V_BACK;

    typedef enum logic [1:0] {
        ACTIVE = 2'b00,
        FRONT  = 2'b01,
        SYNC   = 2'b11,
        BACK   = 2'b10
    } phase_e;

    function automatic logic sync_level(input phase_e ph, input logic pol);
        return (ph == SYNC) ? pol : ~pol;
    endfunction

endpackage

// File: rtl/vga_axis_cnt.sv
// One raster axis: wrapping position counter plus ACTIVE/FRONT/SYNC/BACK phase FSM.
// Latency: cnt and phase update on the clk after en; next-state values are exported.
// Backpressure: none; en is the only advance qualifier.
module vga_axis_cnt
    import vga_pkg::*;
#(
    parameter int SEG_DISPLAY = DEF_H_DISPLAY,
    parameter int SEG_FRONT   = DEF_H_FRONT,
    parameter int SEG_SYNC    = DEF_H_SYNC,
    parameter int SEG_BACK    = DEF_H_BACK
)(
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    output logic [CNT_W-1:0] cnt,
    output logic             nxt_zero,
    output phase_e           phase_nxt
);

    localparam int TOTAL = SEG_DISPLAY + SEG_FRONT + SEG_SYNC + SEG_BACK;

    localparam logic [CNT_W-1:0] LAST     = CNT_W'(TOTAL - 1);
    localparam logic [CNT_W-1:0] FRONT_AT = CNT_W'(SEG_DISPLAY);
    localparam logic [CNT_W-1:0] SYNC_AT  = CNT_W'(SEG_DISPLAY + SEG_FRONT);
    localparam logic [CNT_W-1:0] BACK_AT  = CNT_W'(SEG_DISPLAY + SEG_FRONT + SEG_SYNC);

    logic [CNT_W-1:0] cnt_q, cnt_d;
    phase_e           phase_q, phase_d;

    // Values at or past LAST (including unreachable ones) fold back to 0.
    always_comb begin
        cnt_d = cnt_q;
        if (en) begin
            cnt_d = (cnt_q >= LAST) ? '0 : cnt_q + CNT_W'(1);
        end
    end

    always_comb begin
        phase_d = phase_q;
        if (en) begin
            if (cnt_d < FRONT_AT) begin
                phase_d = ACTIVE;
            end else if (cnt_d < SYNC_AT) begin
                phase_d = FRONT;
            end else if (cnt_d < BACK_AT) begin
                phase_d = SYNC;
            end else begin
                phase_d = BACK;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q   <= '0;
            phase_q <= ACTIVE;
        end else begin
            cnt_q   <= cnt_d;
            phase_q <= phase_d;
        end
    end

    assign cnt       = cnt_q;
    assign nxt_zero  = (cnt_d == '0);
    assign phase_nxt = phase_d;

endmodule

// File: rtl/vga_sync_gen.sv
// VGA raster timing: pixel-rate tick, x/y counters, registered hsync/vsync/video_on, frame_start.
// Latency: outputs change together one clk after p_tick; VGA_SYNC_DELAY_EN adds 2 pixel slots to syncs/video_on.
// Backpressure: none; free-running from clk once rst_n is released.
module vga_sync_gen
    import vga_pkg::*;
#(
    parameter int   CLK_DIV   = 2,
    parameter int   H_DISPLAY = DEF_H_DISPLAY,
    parameter int   H_FRONT   = DEF_H_FRONT,
    parameter int   H_SYNC    = DEF_H_SYNC,
    parameter int   H_BACK    = DEF_H_BACK,
    parameter int   V_DISPLAY = DEF_V_DISPLAY,
    parameter int   V_FRONT   = DEF_V_FRONT,
    parameter int   V_SYNC    = DEF_V_SYNC,
    parameter int   V_BACK    = DEF_V_BACK,
    parameter logic SYNC_POL  = 1'b0
)(
    input  logic             clk,
    input  logic             rst_n,
    output logic             p_tick,
    output logic [CNT_W-1:0] pix_x,
    output logic [CNT_W-1:0] pix_y,
    output logic             video_on,
    output logic             hsync,
    output logic             vsync,
    output logic             frame_start
);

    localparam int              DIV_W    = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);

    logic [DIV_W-1:0] div_cnt_q, div_cnt_d;
    logic             p_tick_q, p_tick_d;
    logic             frame_start_q, frame_start_d;
    logic             hsync_q, hsync_d;
    logic             vsync_q, vsync_d;
    logic             video_on_q, video_on_d;

    logic   h_nxt_zero, v_nxt_zero, v_en;
    phase_e h_phase_nxt, v_phase_nxt;

    // A zero next-x on a tick can only mean the line just wrapped.
    assign v_en = p_tick_q & h_nxt_zero;

    vga_axis_cnt #(
        .SEG_DISPLAY (H_DISPLAY),
        .SEG_FRONT   (H_FRONT),
        .SEG_SYNC    (H_SYNC),
        .SEG_BACK    (H_BACK)
    ) u_h_axis (
        .clk       (clk),
        .rst_n     (rst_n),
        .en        (p_tick_q),
        .cnt       (pix_x),
        .nxt_zero  (h_nxt_zero),
        .phase_nxt (h_phase_nxt)
    );

    vga_axis_cnt #(
        .SEG_DISPLAY (V_DISPLAY),
        .SEG_FRONT   (V_FRONT),
        .SEG_SYNC    (V_SYNC),
        .SEG_BACK    (V_BACK)
    ) u_v_axis (
        .clk       (clk),
        .rst_n     (rst_n),
        .en        (v_en),
        .cnt       (pix_y),
        .nxt_zero  (v_nxt_zero),
        .phase_nxt (v_phase_nxt)
    );

    // Sync/video flops use the axes' next phase so they move in the same clk as pix_x/pix_y.
    always_comb begin
        div_cnt_d     = (div_cnt_q >= DIV_LAST) ? '0 : div_cnt_q + DIV_W'(1);
        p_tick_d      = (div_cnt_q == DIV_LAST);
        frame_start_d = p_tick_d & h_nxt_zero & v_nxt_zero;
        hsync_d       = sync_level(h_phase_nxt, SYNC_POL);
        vsync_d       = sync_level(v_phase_nxt, SYNC_POL);
        video_on_d    = (h_phase_nxt == ACTIVE) && (v_phase_nxt == ACTIVE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            div_cnt_q     <= '0;
            p_tick_q      <= 1'b0;
            frame_start_q <= 1'b0;
            hsync_q       <= ~SYNC_POL;
            vsync_q       <= ~SYNC_POL;
            video_on_q    <= 1'b0;
        end else begin
            div_cnt_q     <= div_cnt_d;
            p_tick_q      <= p_tick_d;
            frame_start_q <= frame_start_d;
            hsync_q       <= hsync_d;
            vsync_q       <= vsync_d;
            video_on_q    <= video_on_d;
        end
    end

    assign p_tick      = p_tick_q;
    assign frame_start = frame_start_q;

`ifdef VGA_SYNC_DELAY_EN
    // Two pixel-slot pipeline matching font ROM + RGB register latency downstream.
    logic [1:0] hsync_dly_q, hsync_dly_d;
    logic [1:0] vsync_dly_q, vsync_dly_d;
    logic [1:0] video_on_dly_q, video_on_dly_d;

    always_comb begin
        hsync_dly_d    = hsync_dly_q;
        vsync_dly_d    = vsync_dly_q;
        video_on_dly_d = video_on_dly_q;
        if (p_tick_q) begin
            hsync_dly_d    = {hsync_dly_q[0], hsync_q};
            vsync_dly_d    = {vsync_dly_q[0], vsync_q};
            video_on_dly_d = {video_on_dly_q[0], video_on_q};
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hsync_dly_q    <= {2{~SYNC_POL}};
            vsync_dly_q    <= {2{~SYNC_POL}};
            video_on_dly_q <= 2'b00;
        end else begin
            hsync_dly_q    <= hsync_dly_d;
            vsync_dly_q    <= vsync_dly_d;
            video_on_dly_q <= video_on_dly_d;
        end
    end

    assign hsync    = hsync_dly_q[1];
    assign vsync    = vsync_dly_q[1];
    assign video_on = video_on_dly_q[1];
`else
    assign hsync    = hsync_q;
    assign vsync    = vsync_q;
    assign video_on = video_on_q;
`endif

endmodule

// File: tb/tb_vga_sync_gen.sv
// Bench for vga_sync_gen on a shrunken raster (33x17 slots, CLK_DIV=2): slot-count model
// compared every clk, plus hand-computed checks of reset, line, frame, wrap and mid-frame reset.
module tb_vga_sync_gen;

    localparam int D  = 2;
    localparam int HD = 20, HF = 4, HS = 6, HB = 3;
    localparam int VD = 10, VF = 2, VS = 2, VB = 3;
    localparam int HT = HD + HF + HS + HB;
    localparam int VT = VD + VF + VS + VB;
    localparam logic POL = 1'b0;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        p_tick;
    logic [10:0] pix_x, pix_y;
    logic        video_on, hsync, vsync, frame_start;

    int vectors = 0;
    int miscompares = 0;
    int cyc = 0;

    vga_sync_gen #(
        .CLK_DIV   (D),
        .H_DISPLAY (HD), .H_FRONT (HF), .H_SYNC (HS), .H_BACK (HB),
        .V_DISPLAY (VD), .V_FRONT (VF), .V_SYNC (VS), .V_BACK (VB),
        .SYNC_POL  (POL)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .p_tick      (p_tick),
        .pix_x       (pix_x),
        .pix_y       (pix_y),
        .video_on    (video_on),
        .hsync       (hsync),
        .vsync       (vsync),
        .frame_start (frame_start)
    );

    always #5 clk = ~clk;

    // Number of rising edges seen since reset release.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) cyc <= 0;
        else        cyc <= cyc + 1;
    end

    task automatic chk(input string name, input int act, input int exp);
        vectors++;
        if (act != exp) begin
            miscompares++;
            $display("FAIL %s at t=%0t: got %0d, expected %0d", name, $time, act, exp);
        end
    endtask

    // Outputs after c edges: slot n = number of pixel advances so far.
    function automatic void model(input int c, output int e_tick, output int e_x, output int e_y,
                                  output int e_vid, output int e_hs, output int e_vs, output int e_fs);
        int n, m, mx, my;
        int deasserted;
        deasserted = (POL == 1'b0) ? 1 : 0;
        if (c == 0) begin
            e_tick = 0; e_x = 0; e_y = 0; e_vid = 0;
            e_hs = deasserted; e_vs = deasserted; e_fs = 0;
            return;
        end
        n      = (c - 1) / D;
        e_tick = (c % D == 0) ? 1 : 0;
        e_x    = n % HT;
        e_y    = (n / HT) % VT;
        e_fs   = (e_tick == 1 && (n % (HT * VT)) == 0) ? 1 : 0;
`ifdef VGA_SYNC_DELAY_EN
        m = n - 2;
`else
        m = n;
`endif
        if (m < 0) begin
            e_vid = 0; e_hs = deasserted; e_vs = deasserted;
        end else begin
            mx    = m % HT;
            my    = (m / HT) % VT;
            e_vid = (mx < HD && my < VD) ? 1 : 0;
            e_hs  = (mx >= HD + HF && mx < HD + HF + HS) ? 1 - deasserted : deasserted;
            e_vs  = (my >= VD + VF && my < VD + VF + VS) ? 1 - deasserted : deasserted;
        end
    endfunction

    always @(negedge clk) begin
        int e_tick, e_x, e_y, e_vid, e_hs, e_vs, e_fs;
        model(cyc, e_tick, e_x, e_y, e_vid, e_hs, e_vs, e_fs);
        chk("cmp_p_tick",      int'(p_tick),      e_tick);
        chk("cmp_pix_x",       int'(pix_x),       e_x);
        chk("cmp_pix_y",       int'(pix_y),       e_y);
        chk("cmp_video_on",    int'(video_on),    e_vid);
        chk("cmp_hsync",       int'(hsync),       e_hs);
        chk("cmp_vsync",       int'(vsync),       e_vs);
        chk("cmp_frame_start", int'(frame_start), e_fs);
    end

    initial begin
        int lows, vids, fall_x, fs_extra, cnt;
        int max_x, max_y, cur_x, cur_y, prev_x, prev_y;
        int exp_fall_x;
`ifdef VGA_SYNC_DELAY_EN
        exp_fall_x = HD + HF + 2;
`else
        exp_fall_x = HD + HF;
`endif

        // Reset held 10 clks.
        rst_n = 1'b0;
        repeat (10) @(posedge clk);
        #1;
        chk("rst_p_tick",      int'(p_tick),      0);
        chk("rst_pix_x",       int'(pix_x),       0);
        chk("rst_pix_y",       int'(pix_y),       0);
        chk("rst_hsync",       int'(hsync),       1);
        chk("rst_vsync",       int'(vsync),       1);
        chk("rst_video_on",    int'(video_on),    0);
        chk("rst_frame_start", int'(frame_start), 0);
        #1 rst_n = 1'b1;

        @(posedge clk); #1;
        chk("edge1_p_tick", int'(p_tick), 0);
        @(posedge clk); #1;
        chk("edge2_p_tick",      int'(p_tick),      1);
        chk("edge2_pix_x",       int'(pix_x),       0);
        chk("edge2_pix_y",       int'(pix_y),       0);
        chk("edge2_hsync",       int'(hsync),       1);
        chk("edge2_vsync",       int'(vsync),       1);
        chk("edge2_frame_start", int'(frame_start), 1);

        // One full line period of clks.
        lows = 0; vids = 0; fall_x = -1; fs_extra = 0;
        for (int i = 0; i < HT * D; i++) begin
            @(posedge clk); #1;
            if (!hsync) begin
                lows++;
                if (fall_x < 0) fall_x = int'(pix_x);
            end
            if (video_on) vids++;
            if (frame_start) fs_extra++;
        end
        chk("line_hsync_low_clks", lows, HS * D);
        chk("line_video_on_clks",  vids, HD * D);
        chk("line_hsync_fall_x",   fall_x, exp_fall_x);
        chk("line_frame_start_once", fs_extra, 0);

        // Next frame_start, then measure a whole frame up to the following one.
        cnt = 0;
        do begin
            @(posedge clk); #1;
            cnt++;
        end while (!frame_start && cnt < 3000);
        chk("frame_start_seen", int'(frame_start), 1);

        cnt = 0; lows = 0; max_x = 0; max_y = 0;
        cur_x = int'(pix_x); cur_y = int'(pix_y); prev_x = -1; prev_y = -1;
        do begin
            @(posedge clk); #1;
            cnt++;
            if (!vsync) lows++;
            if (int'(pix_x) > max_x) max_x = int'(pix_x);
            if (int'(pix_y) > max_y) max_y = int'(pix_y);
            if (int'(pix_x) != cur_x || int'(pix_y) != cur_y) begin
                prev_x = cur_x; prev_y = cur_y;
                cur_x  = int'(pix_x); cur_y = int'(pix_y);
            end
        end while (!frame_start && cnt < 3000);
        chk("frame_period_clks",   cnt, HT * VT * D);
        chk("frame_vsync_low_clks", lows, VS * HT * D);
        chk("frame_pix_x_max",     max_x, HT - 1);
        chk("frame_pix_y_max",     max_y, VT - 1);
        chk("wrap_prev_x",         prev_x, HT - 1);
        chk("wrap_prev_y",         prev_y, VT - 1);
        chk("wrap_pix_x",          int'(pix_x), 0);
        chk("wrap_pix_y",          int'(pix_y), 0);

        // Mid-frame asynchronous reset at (10,5).
        cnt = 0;
        do begin
            @(posedge clk); #1;
            cnt++;
        end while (!(pix_x == 11'd10 && pix_y == 11'd5) && cnt < 3000);
        chk("mid_reached_x", int'(pix_x), 10);
        chk("mid_reached_y", int'(pix_y), 5);
        #1 rst_n = 1'b0;
        #1;
        chk("arst_pix_x",       int'(pix_x),       0);
        chk("arst_pix_y",       int'(pix_y),       0);
        chk("arst_p_tick",      int'(p_tick),      0);
        chk("arst_hsync",       int'(hsync),       1);
        chk("arst_vsync",       int'(vsync),       1);
        chk("arst_video_on",    int'(video_on),    0);
        chk("arst_frame_start", int'(frame_start), 0);
        repeat (3) @(posedge clk);
        #2 rst_n = 1'b1;
        @(posedge clk); #1;
        chk("restart_edge1_p_tick", int'(p_tick), 0);
        @(posedge clk); #1;
        chk("restart_p_tick",      int'(p_tick),      1);
        chk("restart_frame_start", int'(frame_start), 1);
        chk("restart_pix_x",       int'(pix_x),       0);
        chk("restart_pix_y",       int'(pix_y),       0);

        repeat (300) @(posedge clk);
        @(negedge clk); #1;
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
